// File: rtl/decode_alu_dmem.sv
// Single-cycle execute stage: instruction decode, 32-bit ALU and a DEPTH-word data memory.
// Define ALU_OVERFLOW_TRAP_EN to trap signed overflow on ADD/ADDI/SUB (ovf=1, no write-back).
module decode_alu_dmem #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic [31:0] rdata,
    input  logic [31:0] adata,
    output logic [4:0]  src,
    output logic [4:0]  srt,
    output logic [4:0]  dest,
    output logic [4:0]  shift,
    output logic [31:0] imm,
    output logic [11:0] aluctrl,
    output logic [1:0]  dmctrl,
    output logic [31:0] aluout,
    output logic [31:0] wdata,
    output logic        regctrl,
    output logic        ovf
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [11:0] AC_ADD  = 12'h001;
    localparam logic [11:0] AC_SUB  = 12'h002;
    localparam logic [11:0] AC_AND  = 12'h004;
    localparam logic [11:0] AC_OR   = 12'h008;
    localparam logic [11:0] AC_XOR  = 12'h010;
    localparam logic [11:0] AC_NOR  = 12'h020;
    localparam logic [11:0] AC_SLT  = 12'h040;
    localparam logic [11:0] AC_SLTU = 12'h080;
    localparam logic [11:0] AC_SLL  = 12'h100;
    localparam logic [11:0] AC_SRL  = 12'h200;
    localparam logic [11:0] AC_SRA  = 12'h400;
    localparam logic [11:0] AC_LUI  = 12'h800;

    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic          rtype;
    logic          is_load;
    logic          is_store;
    logic          trap_op;
    logic [31:0]   simm;
    logic [31:0]   zimm;
    logic [31:0]   opb;
    logic [31:0]   sum;
    logic [31:0]   diff;
    logic [31:0]   result;
    logic [AW-1:0] idx;
    logic [31:0]   mem [DEPTH];

    assign opcode = ir[31:26];
    assign funct  = ir[5:0];
    assign src    = ir[25:21];
    assign srt    = ir[20:16];
    assign shift  = ir[10:6];
    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign zimm   = {16'h0000, ir[15:0]};
    assign dest   = rtype ? ir[15:11] : ir[20:16];

    // Instruction decode: one-hot ALU op, immediate form and memory direction.
    always_comb begin : decode
        aluctrl  = '0;
        rtype    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        trap_op  = 1'b0;
        imm      = '0;
        case (opcode)
            OP_RTYPE: begin
                rtype = 1'b1;
                case (funct)
                    FN_ADD:  begin aluctrl = AC_ADD; trap_op = 1'b1; end
                    FN_SUB:  begin aluctrl = AC_SUB; trap_op = 1'b1; end
                    FN_AND:  aluctrl = AC_AND;
                    FN_OR:   aluctrl = AC_OR;
                    FN_XOR:  aluctrl = AC_XOR;
                    FN_NOR:  aluctrl = AC_NOR;
                    FN_SLT:  aluctrl = AC_SLT;
                    FN_SLTU: aluctrl = AC_SLTU;
                    FN_SLL:  aluctrl = AC_SLL;
                    FN_SRL:  aluctrl = AC_SRL;
                    FN_SRA:  aluctrl = AC_SRA;
                    default: aluctrl = '0;
                endcase
            end
            OP_ADDI:  begin aluctrl = AC_ADD;  imm = simm; trap_op = 1'b1; end
            OP_SLTI:  begin aluctrl = AC_SLT;  imm = simm; end
            OP_SLTIU: begin aluctrl = AC_SLTU; imm = simm; end
            OP_ANDI:  begin aluctrl = AC_AND;  imm = zimm; end
            OP_ORI:   begin aluctrl = AC_OR;   imm = zimm; end
            OP_XORI:  begin aluctrl = AC_XOR;  imm = zimm; end
            OP_LUI:   begin aluctrl = AC_LUI;  imm = zimm; end
            OP_LW:    begin aluctrl = AC_ADD;  imm = simm; is_load  = 1'b1; end
            OP_SW:    begin aluctrl = AC_ADD;  imm = simm; is_store = 1'b1; end
            default:  aluctrl = '0;
        endcase
    end

    assign opb  = rtype ? adata : imm;
    assign sum  = rdata + opb;
    assign diff = rdata - opb;

    // ALU; an all-zero aluctrl (unsupported instruction) yields 0.
    always_comb begin : alu
        result = '0;
        case (aluctrl)
            AC_ADD:  result = sum;
            AC_SUB:  result = diff;
            AC_AND:  result = rdata & opb;
            AC_OR:   result = rdata | opb;
            AC_XOR:  result = rdata ^ opb;
            AC_NOR:  result = ~(rdata | opb);
            AC_SLT:  result = {31'd0, ($signed(rdata) < $signed(opb))};
            AC_SLTU: result = {31'd0, (rdata < opb)};
            AC_SLL:  result = adata << shift;
            AC_SRL:  result = adata >> shift;
            AC_SRA:  result = 32'($signed(adata) >>> shift);
            AC_LUI:  result = {imm[15:0], 16'h0000};
            default: result = '0;
        endcase
    end

    assign aluout = result;

`ifdef ALU_OVERFLOW_TRAP_EN
    logic ovf_raw;

    // Signed overflow: operands agree in sign (after negation for SUB) but the result does not.
    always_comb begin : ovf_detect
        ovf_raw = 1'b0;
        if (trap_op) begin
            if (aluctrl == AC_SUB) begin
                ovf_raw = (rdata[31] != opb[31]) && (diff[31] != rdata[31]);
            end else begin
                ovf_raw = (rdata[31] == opb[31]) && (sum[31] != rdata[31]);
            end
        end
    end

    assign ovf = rst_n & ovf_raw;
`else
    logic unused_trap_op;
    assign unused_trap_op = trap_op;
    assign ovf            = 1'b0;
`endif

    // Byte address wraps onto the word array; low two bits are ignored.
    assign idx     = aluout[AW+1:2];
    assign dmctrl  = rst_n ? {is_store, is_load} : 2'b00;
    assign wdata   = !rst_n ? '0 : (is_load ? mem[idx] : aluout);
    assign regctrl = rst_n && (aluctrl != 12'h000) && !is_store && (dest != 5'd0) && !ovf;

    // Data memory: cleared asynchronously while in reset, stores commit on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin : dmem
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (is_store) begin
            mem[idx] <= adata;
        end
    end

endmodule

// File: tb/tb_decode_alu_dmem.sv
// Randomized self-checking bench for decode_alu_dmem against an instruction-level reference model.
module tb_decode_alu_dmem;

    localparam int unsigned DEPTH = 64;
`ifdef ALU_OVERFLOW_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic [31:0] rdata;
    logic [31:0] adata;
    logic [4:0]  src;
    logic [4:0]  srt;
    logic [4:0]  dest;
    logic [4:0]  shift;
    logic [31:0] imm;
    logic [11:0] aluctrl;
    logic [1:0]  dmctrl;
    logic [31:0] aluout;
    logic [31:0] wdata;
    logic        regctrl;
    logic        ovf;

    int n_checks;
    int n_errors;

    logic [31:0] ref_mem [DEPTH];

    typedef struct packed {
        logic        known;
        logic [11:0] aluctrl;
        logic [1:0]  dmctrl;
        logic [31:0] aluout;
        logic [31:0] wdata;
        logic [31:0] imm;
        logic [4:0]  dest;
        logic        regctrl;
        logic        ovf;
    } exp_t;

    decode_alu_dmem #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ir      (ir),
        .rdata   (rdata),
        .adata   (adata),
        .src     (src),
        .srt     (srt),
        .dest    (dest),
        .shift   (shift),
        .imm     (imm),
        .aluctrl (aluctrl),
        .dmctrl  (dmctrl),
        .aluout  (aluout),
        .wdata   (wdata),
        .regctrl (regctrl),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        return int'((addr / 32'd4) % 32'(DEPTH));
    endfunction

    // Reference: what the instruction means, computed with plain arithmetic.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] a,
                                   input logic [31:0] b, input logic rst_ok);
        exp_t        e;
        int          kind;
        logic [31:0] se;
        logic [31:0] ze;
        logic [31:0] bop;
        logic [4:0]  sh;
        logic        ld;
        logic        st;
        logic        arith;
        longint      wide;
        e     = '0;
        kind  = -1;
        ld    = 1'b0;
        st    = 1'b0;
        arith = 1'b0;
        wide  = 0;
        se    = {{16{i[15]}}, i[15:0]};
        ze    = {16'h0000, i[15:0]};
        sh    = i[10:6];
        if (i[31:26] == 6'h00) begin
            e.dest = i[15:11];
            case (i[5:0])
                6'h20: begin kind = 0; arith = 1'b1; end
                6'h22: begin kind = 1; arith = 1'b1; end
                6'h24: kind = 2;
                6'h25: kind = 3;
                6'h26: kind = 4;
                6'h27: kind = 5;
                6'h2A: kind = 6;
                6'h2B: kind = 7;
                6'h00: kind = 8;
                6'h02: kind = 9;
                6'h03: kind = 10;
                default: kind = -1;
            endcase
            bop = b;
        end else begin
            e.dest = i[20:16];
            case (i[31:26])
                6'h08: begin kind = 0;  e.imm = se; arith = 1'b1; end
                6'h0A: begin kind = 6;  e.imm = se; end
                6'h0B: begin kind = 7;  e.imm = se; end
                6'h0C: begin kind = 2;  e.imm = ze; end
                6'h0D: begin kind = 3;  e.imm = ze; end
                6'h0E: begin kind = 4;  e.imm = ze; end
                6'h0F: begin kind = 11; e.imm = ze; end
                6'h23: begin kind = 0;  e.imm = se; ld = 1'b1; end
                6'h2B: begin kind = 0;  e.imm = se; st = 1'b1; end
                default: kind = -1;
            endcase
            bop = e.imm;
        end
        e.known = (kind >= 0);
        if (e.known) begin
            e.aluctrl = 12'(1) << kind;
            case (kind)
                0:  e.aluout = a + bop;
                1:  e.aluout = a - bop;
                2:  e.aluout = a & bop;
                3:  e.aluout = a | bop;
                4:  e.aluout = a ^ bop;
                5:  e.aluout = ~(a | bop);
                6:  e.aluout = (longint'($signed(a)) < longint'($signed(bop))) ? 32'd1 : 32'd0;
                7:  e.aluout = (64'(a) < 64'(bop)) ? 32'd1 : 32'd0;
                8:  e.aluout = b << sh;
                9:  e.aluout = b >> sh;
                10: e.aluout = b[31] ? ~((~b) >> sh) : (b >> sh);
                default: e.aluout = {i[15:0], 16'h0000};
            endcase
            if (kind == 1) wide = longint'($signed(a)) - longint'($signed(bop));
            else           wide = longint'($signed(a)) + longint'($signed(bop));
            e.ovf     = TRAP && arith && (wide > 64'sd2147483647 || wide < -64'sd2147483648);
            e.dmctrl  = st ? 2'b10 : (ld ? 2'b01 : 2'b00);
            e.wdata   = ld ? ref_mem[word_of(e.aluout)] : e.aluout;
            e.regctrl = !st && (e.dest != 5'd0) && !e.ovf;
        end
        if (!rst_ok) begin
            e.dmctrl  = 2'b00;
            e.regctrl = 1'b0;
            e.ovf     = 1'b0;
            e.wdata   = '0;
        end
        return e;
    endfunction

    // Present one instruction from a falling edge, compare, then clock it through one rising edge.
    task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                         input bit do_check);
        exp_t e;
        ir    = i;
        rdata = a;
        adata = b;
        #1;
        e = model(i, a, b, rst_n);
        if (do_check) begin
            check($sformatf("src ir=%h", i), 32'(src), 32'(i[25:21]));
            check($sformatf("srt ir=%h", i), 32'(srt), 32'(i[20:16]));
            check($sformatf("shift ir=%h", i), 32'(shift), 32'(i[10:6]));
            check($sformatf("aluctrl ir=%h", i), 32'(aluctrl), 32'(e.aluctrl));
            check($sformatf("dmctrl ir=%h", i), 32'(dmctrl), 32'(e.dmctrl));
            check($sformatf("regctrl ir=%h", i), 32'(regctrl), 32'(e.regctrl));
            check($sformatf("ovf ir=%h", i), 32'(ovf), 32'(e.ovf));
            check($sformatf("wdata ir=%h a=%h b=%h", i, a, b), wdata, e.wdata);
            if (e.known) begin
                check($sformatf("dest ir=%h", i), 32'(dest), 32'(e.dest));
                check($sformatf("imm ir=%h", i), imm, e.imm);
            end
            if (rst_n) check($sformatf("aluout ir=%h a=%h b=%h", i, a, b), aluout, e.aluout);
        end
        @(posedge clk);
        if (rst_n && e.dmctrl == 2'b10) ref_mem[word_of(e.aluout)] = b;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] pick_funct(input int k);
        case (k)
            0: return 6'h20;  1: return 6'h22;  2: return 6'h24;  3: return 6'h25;
            4: return 6'h26;  5: return 6'h27;  6: return 6'h2A;  7: return 6'h2B;
            8: return 6'h00;  9: return 6'h02;  default: return 6'h03;
        endcase
    endfunction

    function automatic logic [5:0] pick_op(input int k);
        case (k)
            0: return 6'h08;  1: return 6'h0A;  2: return 6'h0B;  3: return 6'h0C;
            4: return 6'h0D;  5: return 6'h0E;  6: return 6'h0F;  7: return 6'h23;
            default: return 6'h2B;
        endcase
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        for (int k = 0; k < 9; k++) if (pick_op(k) == op) return 1'b1;
        return op == 6'h00;
    endfunction

    function automatic bit fn_known(input logic [5:0] fn);
        for (int k = 0; k < 11; k++) if (pick_funct(k) == fn) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        ir       = '0;
        rdata    = '0;
        adata    = '0;
        for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = '0;
        @(negedge clk);

        // In reset: decode tracks ir, controls are zero, a store at the edge is dropped.
        apply(i_ins(6'h2B, 5'd1, 5'd2, 16'h0030), 32'h0, 32'h1111_2222, 1'b1);
        apply(32'h0022_1820, 32'd5, 32'd7, 1'b1);
        check("rst_regctrl", 32'(regctrl), 32'd0);

        // First edge after release commits a store.
        rst_n = 1'b1;
        apply(i_ins(6'h2B, 5'd1, 5'd2, 16'h0004), 32'h0, 32'hCAFE_F00D, 1'b0);
        apply(i_ins(6'h23, 5'd1, 5'd3, 16'h0030), 32'h0, 32'h0, 1'b1);
        check("blocked_store", wdata, 32'h0);
        apply(i_ins(6'h23, 5'd1, 5'd3, 16'h0004), 32'h0, 32'h0, 1'b1);
        check("first_edge_store", wdata, 32'hCAFE_F00D);

        apply(32'h0022_1820, 32'd5, 32'd7, 1'b1);
        check("plan_add_aluout", aluout, 32'd12);
        check("plan_add_ctrl", 32'({aluctrl, dest, regctrl}), 32'({12'h001, 5'd3, 1'b1}));
        apply(32'hAC22_0010, 32'h20, 32'hDEAD_BEEF, 1'b1);
        apply(32'h8C23_0010, 32'h20, 32'h0, 1'b1);
        check("plan_lw", wdata, 32'hDEAD_BEEF);
        apply(i_ins(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd1, 32'd9, 1'b1);
        check("plan_addi", aluout, 32'h0);
        apply(i_ins(6'h0D, 5'd1, 5'd5, 16'hFFFF), 32'd0, 32'd9, 1'b1);
        check("plan_ori", aluout, 32'h0000_FFFF);
        apply(i_ins(6'h0F, 5'd0, 5'd6, 16'h1234), 32'h5555_5555, 32'd0, 1'b1);
        check("plan_lui", aluout, 32'h1234_0000);
        apply(r_ins(6'h03, 5'd0, 5'd2, 5'd7, 5'd4), 32'd0, 32'h8000_0000, 1'b1);
        check("plan_sra", aluout, 32'hF800_0000);
        apply(r_ins(6'h2A, 5'd1, 5'd2, 5'd8, 5'd0), 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("plan_slt", aluout, 32'd1);
        apply(r_ins(6'h2B, 5'd1, 5'd2, 5'd8, 5'd0), 32'hFFFF_FFFF, 32'd1, 1'b1);
        check("plan_sltu", aluout, 32'd0);
        apply(r_ins(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 32'h7FFF_FFFF, 32'd1, 1'b1);
`ifdef ALU_OVERFLOW_TRAP_EN
        check("plan_ovf", 32'({ovf, regctrl}), 32'({1'b1, 1'b0}));
`else
        check("plan_wrap", aluout, 32'h8000_0000);
        check("plan_wrap_regctrl", 32'({ovf, regctrl}), 32'({1'b0, 1'b1}));
`endif
        apply(r_ins(6'h20, 5'd1, 5'd2, 5'd0, 5'd0), 32'd3, 32'd4, 1'b1);
        check("dest0_regctrl", 32'(regctrl), 32'd0);
        apply({6'h3F, 26'h022_1820}, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        check("nop_ctrl", 32'({aluctrl, dmctrl, regctrl, ovf}), 32'd0);
        check("nop_data", aluout | wdata, 32'd0);

        // Store to word 2, reset pulse between edges, then the word reads back as zero.
        apply(i_ins(6'h2B, 5'd1, 5'd2, 16'h0008), 32'h0, 32'h55, 1'b1);
        apply(i_ins(6'h23, 5'd1, 5'd3, 16'h0008), 32'h0, 32'h0, 1'b1);
        check("pre_pulse_lw", wdata, 32'h55);
        ir = {6'h3F, 26'h0};
        @(posedge clk);
        #2 rst_n = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = '0;
        #1 check("pulse_wdata", wdata, 32'h0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        apply(i_ins(6'h23, 5'd1, 5'd3, 16'h0008), 32'h0, 32'h0, 1'b1);
        check("post_pulse_lw", wdata, 32'h0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] i;
            logic [31:0] a;
            logic [31:0] b;
            logic [5:0]  op;
            logic [5:0]  fn;
            int          pick;
            pick = $urandom_range(0, 21);
            a    = rand_val();
            b    = rand_val();
            if (pick < 11) begin
                i = r_ins(pick_funct(pick), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            end else if (pick < 20) begin
                op = pick_op(pick - 11);
                if (op == 6'h23 || op == 6'h2B) begin
                    a = 32'($urandom_range(0, 1023));
                    i = i_ins(op, 5'($urandom), 5'($urandom),
                              ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63)));
                end else begin
                    i = i_ins(op, 5'($urandom), 5'($urandom), 16'($urandom));
                end
            end else if (pick == 20) begin
                op = 6'($urandom_range(1, 63));
                while (op_known(op)) op = 6'($urandom_range(1, 63));
                i = {op, 26'($urandom)};
            end else begin
                fn = 6'($urandom);
                while (fn_known(fn)) fn = 6'($urandom);
                i = {6'h00, 20'($urandom), fn};
            end
            apply(i, a, b, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1);
    end

endmodule

// File: doc/decode_alu_dmem.md
# decode_alu_dmem

Execute-stage datapath of the single-cycle RISC core: decodes a 32-bit MIPS-style instruction, computes the result in a 32-bit ALU, and performs the data-memory access. It sits between instruction memory and the register file. It drives the register-file read addresses, and takes back the two operand values. It returns the write-back data, destination, and write enable.

## Interface
- `DEPTH`, 64: data-memory size in 32-bit words (power of two, 4..1024).
- `clk`  in  1  system clock; memory writes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ir`  in  32  instruction word.
- `rdata`  in  32  register-file value at `src` (rs).
- `adata`  in  32  register-file value at `srt` (rt).
- `src`  out  5  rs address, `ir[25:21]`.
- `srt`  out  5  rt address, `ir[20:16]`.
- `dest`  out  5  write-back register address.
- `shift`  out  5  shift amount, `ir[10:6]`.
- `imm`  out  32  extended immediate.
- `aluctrl`  out  12  one-hot ALU operation.
- `dmctrl`  out  2  memory control: 00 none, 01 read, 10 write, 11 is never driven.
- `aluout`  out  32  ALU result, which is also the memory byte address.
- `wdata`  out  32  write-back data.
- `regctrl`  out  1  register write enable.
- `ovf`  out  1  signed overflow trap flag.

## Operation
- Fields: opcode `ir[31:26]`, funct `ir[5:0]`, rd `ir[15:11]`.
- R-type (opcode 0x00), selected by funct:
  - ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLT 0x2A, SLTU 0x2B.
  - SLL 0x00, SRL 0x02, SRA 0x03.
  - R-type uses `dest` = rd.
- I-type, selected by opcode:
  - ADDI 0x08, SLTI 0x0A, SLTIU 0x0B, ANDI 0x0C, ORI 0x0D, XORI 0x0E, LUI 0x0F.
  - LW 0x23, SW 0x2B.
  - I-type uses `dest` = rt.
- `aluctrl` one-hot bit assignment:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI.
  - ADDI, LW and SW use ADD. SLTI uses SLT, SLTIU uses SLTU. ANDI, ORI and XORI use AND, OR and XOR respectively.
- `imm` extension:
  - Sign-extended `ir[15:0]` for ADDI, SLTI, SLTIU, LW, SW.
  - Zero-extended for ANDI, ORI, XORI, LUI.
  - 0 for R-type.
- ALU operands:
  - A = `rdata`.
  - B = `adata` for R-type, `imm` for I-type.
  - Shifts operate on `adata` by `shift`.
  - LUI result = `{imm[15:0],16'h0000}`.
  - SLT is a signed compare and SLTU an unsigned compare; both give 32'h1 or 32'h0.
  - Arithmetic wraps modulo 2^32.
- Memory access:
  - Word index = `aluout[log2(DEPTH)+1:2]`.
  - Low two address bits are ignored.
  - Upper address bits are ignored, so addresses wrap.
  - LW: `dmctrl`=01, `wdata` = mem[index].
  - SW: `dmctrl`=10, mem[index] <= `adata` on the rising edge; `regctrl`=0.
- Write-back:
  - `wdata` = memory word for LW, otherwise `aluout`.
  - `regctrl`=1 for all ALU ops and LW, unless `dest`==0, in which case it is forced to 0.
- Unsupported opcode or funct executes as a NOP: `aluctrl`=0, `dmctrl`=00, `regctrl`=0, `aluout`=0, `wdata`=0, `ovf`=0.

## Timing
- Decode, ALU, memory read and write-back are purely combinational from `ir`, `rdata`, `adata`. Zero-cycle latency; outputs are valid within the same cycle.
- Memory write is committed at the rising `clk` edge. A read of the same word in that cycle returns the old value; the new value is visible after the edge.
- While `rst_n`=0:
  - All memory words are cleared to 0 asynchronously.
  - `regctrl`=0, `dmctrl`=00, `ovf`=0.
  - Writes are blocked and `wdata`=0.
  - Decode fields (`src`, `srt`, `dest`, `shift`, `imm`, `aluctrl`) still follow `ir`.
- Reset deassertion takes effect at the next rising edge. A store presented on the first edge after release is committed.

## Configuration
- `ALU_OVERFLOW_TRAP_EN` defined:
  - Signed overflow on ADD, ADDI or SUB sets `ovf`=1 and forces `regctrl`=0, so the destination register is not written.
  - LW/SW address overflow does not trap.
- `ALU_OVERFLOW_TRAP_EN` undefined: `ovf` is tied to 0 and results wrap silently.

## Test plan
- ADD: `ir`=0x00221820 (add $3,$1,$2), `rdata`=5, `adata`=7 -> `aluctrl`=12'h001, `aluout`=12, `dest`=3, `regctrl`=1, `wdata`=12.
- SW then LW:
  - SW `ir`=0xAC220010, `rdata`=0x20, `adata`=0xDEADBEEF, then clock one edge.
  - LW `ir`=0x8C230010 with `rdata`=0x20 -> `dmctrl`=01, `wdata`=0xDEADBEEF, `regctrl`=1, `dest`=3.
- Immediates:
  - ADDI with imm 0xFFFF and `rdata`=1 -> `aluout`=0.
  - ORI with imm 0xFFFF and `rdata`=0 -> `aluout`=0x0000FFFF.
  - LUI with imm 0x1234 -> 0x12340000.
- Shift and compare:
  - SRA with `adata`=0x80000000, `shift`=4 -> 0xF8000000.
  - SLT with -1 vs 1 -> 1; SLTU with -1 vs 1 -> 0.
- Overflow and NOP:
  - ADD 0x7FFFFFFF+1 -> with `ALU_OVERFLOW_TRAP_EN`: `ovf`=1, `regctrl`=0. Without it: `aluout`=0x80000000, `regctrl`=1.
  - Opcode 0x3F -> all control outputs 0.
- Reset:
  - Store 0x55 to word 2, pulse `rst_n` low mid-cycle, then LW from address 8 -> `wdata`=0.
  - A write with `rst_n`=0 at the edge is not stored.
